// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and defaults for the Dmem arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 64;

    // Owner of the read data returning from Dmem in the following cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_AUX  = 2'b10
    } owner_e;

    typedef enum logic {
        WIN_CORE = 1'b0,
        WIN_AUX  = 1'b1
    } win_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Core, aux and Dmem-side bus bundle of the Dmem arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              core_en;
    logic              core_wr_en;
    logic [0:ADDR_W-1] core_addr;
    logic [0:DATA_W-1] core_wdata;
    logic [0:DATA_W-1] core_rdata;
    logic              core_stall;

    logic              aux_req;
    logic              aux_wr_en;
    logic [0:ADDR_W-1] aux_addr;
    logic [0:DATA_W-1] aux_wdata;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [0:DATA_W-1] aux_rdata;

    logic              mem_en;
    logic              mem_wr_en;
    logic [0:ADDR_W-1] mem_addr;
    logic [0:DATA_W-1] mem_wdata;
    logic [0:DATA_W-1] mem_rdata;

    // Arbiter view
    modport slave (
        input  core_en, core_wr_en, core_addr, core_wdata,
        input  aux_req, aux_wr_en, aux_addr, aux_wdata,
        input  mem_rdata,
        output core_rdata, core_stall,
        output aux_gnt, aux_rvalid, aux_rdata,
        output mem_en, mem_wr_en, mem_addr, mem_wdata
    );

    // Requesters and Dmem view
    modport master (
        output core_en, core_wr_en, core_addr, core_wdata,
        output aux_req, aux_wr_en, aux_addr, aux_wdata,
        output mem_rdata,
        input  core_rdata, core_stall,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  mem_en, mem_wr_en, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_wait_counter
//  Description : Saturating clear/increment counter bounding aux starvation.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int CNT_W        = 3,
    parameter int AUX_MAX_WAIT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_inc,
    output logic      o_limit_hit
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(AUX_MAX_WAIT);

    logic [CNT_W-1:0] r_wait_cnt;

    // Clear has priority over increment; counting stops at the bound
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wait_cnt <= '0;
        end else if (i_inc && (r_wait_cnt != C_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign o_limit_hit = (r_wait_cnt == C_MAX);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares single-port Dmem between the core and an aux requester.
//                Define DMEM_ARB_RR_EN for round-robin instead of core priority.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int AUX_MAX_WAIT = 4,
    parameter int CNT_W        = 3
) (
    input  wire logic     Clock,
    input  wire logic     Reset,
    dmem_arbiter_if.slave bus
);

    logic              w_core_win;
    logic              w_aux_win;
    logic              w_mem_en;
    logic              w_mem_wr_en;
    logic [0:ADDR_W-1] w_mem_addr;
    logic [0:DATA_W-1] w_mem_wdata;
    logic              w_aux_rvalid;
    owner_e            r_rd_owner;
    owner_e            w_rd_owner_nxt;

`ifdef DMEM_ARB_RR_EN
    win_e r_last_win;

    always_comb begin
        w_core_win = 1'b0;
        w_aux_win  = 1'b0;
        if (!Reset) begin
            if (bus.core_en && bus.aux_req) begin
                w_aux_win  = (r_last_win == WIN_CORE);
                w_core_win = (r_last_win == WIN_AUX);
            end else begin
                w_core_win = bus.core_en;
                w_aux_win  = bus.aux_req;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_last_win <= WIN_CORE;
        end else if (w_core_win) begin
            r_last_win <= WIN_CORE;
        end else if (w_aux_win) begin
            r_last_win <= WIN_AUX;
        end
    end
`else
    logic w_limit_hit;

    arb_wait_counter #(
        .CNT_W        (CNT_W),
        .AUX_MAX_WAIT (AUX_MAX_WAIT)
    ) u_wait_cnt (
        .clk         (Clock),
        .rst         (Reset),
        .i_clr       (w_aux_win || !bus.aux_req),
        .i_inc       (bus.aux_req && !w_aux_win),
        .o_limit_hit (w_limit_hit)
    );

    // Core priority, except for the forced aux slot once the wait bound is hit
    always_comb begin
        w_core_win = 1'b0;
        w_aux_win  = 1'b0;
        if (!Reset) begin
            w_aux_win  = bus.aux_req && (!bus.core_en || w_limit_hit);
            w_core_win = bus.core_en && !w_aux_win;
        end
    end
`endif

    always_comb begin
        w_mem_en       = 1'b0;
        w_mem_wr_en    = 1'b0;
        w_mem_addr     = '0;
        w_mem_wdata    = '0;
        w_rd_owner_nxt = OWN_NONE;
        if (w_core_win) begin
            w_mem_en    = 1'b1;
            w_mem_wr_en = bus.core_wr_en;
            w_mem_addr  = bus.core_addr;
            w_mem_wdata = bus.core_wdata;
            if (!bus.core_wr_en) w_rd_owner_nxt = OWN_CORE;
        end else if (w_aux_win) begin
            w_mem_en    = 1'b1;
            w_mem_wr_en = bus.aux_wr_en;
            w_mem_addr  = bus.aux_addr;
            w_mem_wdata = bus.aux_wdata;
            if (!bus.aux_wr_en) w_rd_owner_nxt = OWN_AUX;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // Reset also masks a return already in flight from the previous cycle
    assign w_aux_rvalid   = (r_rd_owner == OWN_AUX) && !Reset;

    assign bus.mem_en     = w_mem_en;
    assign bus.mem_wr_en  = w_mem_wr_en;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.core_rdata = Reset ? '0 : bus.mem_rdata;
    assign bus.core_stall = bus.core_en && w_aux_win;
    assign bus.aux_gnt    = w_aux_win;
    assign bus.aux_rvalid = w_aux_rvalid;
    assign bus.aux_rdata  = w_aux_rvalid ? bus.mem_rdata : '0;

    // Aux must keep requesting until granted; a withdrawn request is lost
    a_aux_req_held : assert property (
        @(posedge Clock) disable iff (Reset)
        (bus.aux_req && !w_aux_win) |=> bus.aux_req
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Scoreboard bench for dmem_arbiter with a behavioural Dmem.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic Clock;
    logic Reset;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(64)) bus ();

    dmem_arbiter #(
        .ADDR_W       (8),
        .DATA_W       (64),
        .AUX_MAX_WAIT (4),
        .CNT_W        (3)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [63:0] pat(input int i);
        if (i == 16) return 64'hA5A5_0000_0000_5A5A;
        return 64'hC0DE_0000_0000_0000 | 64'(i * 3 + 1);
    endfunction

    // Behavioural single-port Dmem: one-cycle read latency
    logic [63:0] dmem [256];
    always @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) dmem[i] <= pat(i);
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_wr_en) dmem[bus.mem_addr] <= bus.mem_wdata;
            else               bus.mem_rdata      <= dmem[bus.mem_addr];
        end
    end

    logic [63:0] ref_mem [256];
    logic [63:0] core_q [$];
    logic [63:0] aux_q  [$];
    logic        core_pend;
    logic        aux_pend;
    int          n_checks;
    int          n_errors;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check at negedge, record expectations, advance
    task automatic step(input logic rst,
                        input logic ce, input logic cw, input logic [7:0] ca, input logic [63:0] cd,
                        input logic ar, input logic aw, input logic [7:0] aa, input logic [63:0] ad,
                        input logic ec, input logic ea);
        logic [63:0] exp_d;
        Reset          = rst;
        bus.core_en    = ce;
        bus.core_wr_en = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.aux_req    = ar;
        bus.aux_wr_en  = aw;
        bus.aux_addr   = aa;
        bus.aux_wdata  = ad;
        @(negedge Clock);
        check_val("aux_gnt",    64'(bus.aux_gnt),    64'(ea));
        check_val("core_stall", 64'(bus.core_stall), 64'(ce & ea));
        check_val("mem_en",     64'(bus.mem_en),     64'(ec | ea));
        check_val("mem_wr_en",  64'(bus.mem_wr_en),  64'((ec & cw) | (ea & aw)));
        check_val("mem_addr",   64'(bus.mem_addr),   ec ? 64'(ca) : (ea ? 64'(aa) : 64'h0));
        check_val("mem_wdata",  64'(bus.mem_wdata),  ec ? cd : (ea ? ad : 64'h0));
        check_val("aux_rvalid", 64'(bus.aux_rvalid), 64'(aux_pend & ~rst));
        exp_d = '0;
        if (aux_pend) exp_d = aux_q.pop_front();
        check_val("aux_rdata",  64'(bus.aux_rdata),  (aux_pend && !rst) ? exp_d : 64'h0);
        if (core_pend) begin
            exp_d = core_q.pop_front();
            if (!rst) check_val("core_rdata", 64'(bus.core_rdata), exp_d);
        end
        if (rst) check_val("core_rdata_rst", 64'(bus.core_rdata), 64'h0);
        aux_pend  = 1'b0;
        core_pend = 1'b0;
        if (rst) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        end
        if (ec) begin
            if (cw) ref_mem[ca] = cd;
            else begin core_q.push_back(ref_mem[ca]); core_pend = 1'b1; end
        end else if (ea) begin
            if (aw) ref_mem[aa] = ad;
            else begin aux_q.push_back(ref_mem[aa]); aux_pend = 1'b1; end
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        core_pend = 1'b0;
        aux_pend  = 1'b0;
        Reset     = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        bus.core_en = 1'b0; bus.core_wr_en = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.aux_req = 1'b0; bus.aux_wr_en  = 1'b0; bus.aux_addr  = '0; bus.aux_wdata  = '0;
        @(posedge Clock);
        #1;

        // Reset with both sides requesting: everything quiet
        repeat (2) step(1, 1, 0, 8'h10, 64'h0, 1, 0, 8'h30, 64'h0, 0, 0);

`ifdef DMEM_ARB_RR_EN
        // Both requesting continuously: aux first, then alternate
        for (int i = 0; i < 6; i++)
            step(0, 1, 0, 8'(8'h10 + i), 64'h0, 1, 0, 8'h30, 64'h0, (i % 2) == 1, (i % 2) == 0);
        step(0, 0, 0, 8'h00, 64'h0, 1, 0, 8'h31, 64'h0, 0, 1);
        step(0, 1, 0, 8'h12, 64'h0, 1, 0, 8'h32, 64'h0, 1, 0);
        step(0, 1, 0, 8'h13, 64'h0, 1, 0, 8'h32, 64'h0, 0, 1);
        step(0, 1, 0, 8'h14, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
        step(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0);
`else
        // Core saturates the port; aux forced in on the fifth cycle
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 8'(8'h10 + i), 64'h0, 1, 0, 8'h30, 64'h0, 1, 0);
        check_val("wait_cnt_sat", 64'(dut.u_wait_cnt.r_wait_cnt), 64'd4);
        step(0, 1, 0, 8'h14, 64'h0, 1, 0, 8'h30, 64'h0, 0, 1);
        check_val("wait_cnt_clr", 64'(dut.u_wait_cnt.r_wait_cnt), 64'd0);
        step(0, 1, 0, 8'h14, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
        step(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0);

        // Aux write then aux read-back
        step(0, 0, 0, 8'h00, 64'h0, 1, 1, 8'h20, 64'hDEAD_BEEF_0000_0001, 0, 1);
        step(0, 0, 0, 8'h00, 64'h0, 1, 0, 8'h20, 64'h0, 0, 1);
        // Core write then core read-back
        step(0, 1, 1, 8'h40, 64'h1234_5678_9ABC_DEF0, 0, 0, 8'h00, 64'h0, 1, 0);
        step(0, 1, 0, 8'h40, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);

        // Contention on one address: core reads old value, aux write lands next
        step(0, 1, 0, 8'h41, 64'h0, 1, 1, 8'h41, 64'h5555_AAAA_5555_AAAA, 1, 0);
        step(0, 0, 0, 8'h00, 64'h0, 1, 1, 8'h41, 64'h5555_AAAA_5555_AAAA, 0, 1);
        step(0, 1, 0, 8'h41, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
        step(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0);

        // Reset right after an aux read grant masks its return
        step(0, 0, 0, 8'h00, 64'h0, 1, 0, 8'h20, 64'h0, 0, 1);
        step(1, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0);
        step(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0);
        step(0, 1, 0, 8'h10, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
        step(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
